pc_sequencer: RTL

Program-counter and branch sequencer for the processor fetch stage. Holds the 12-bit PC and applies sequential increment, conditional LUT jumps, call/return through a small return stack, stall and halt. Drives the 5-bit jump pointer into the jump lookup table and takes the 12-bit absolute target back combinationally, in the same cycle. Sits between the instruction decoder/ALU flags and the instruction ROM address port.

---
 rtl/pc_seq_pkg.sv | 19 +
 rtl/ret_stack.sv | 64 ++++++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
//   PC_W     : PC and jump-target width
//   JPTR_W   : jump-table pointer width
//   RS_DEPTH : return-stack entries (power of two)
package pc_seq_pkg;

  localparam int unsigned PC_W     = 12;
  localparam int unsigned JPTR_W   = 5;
  localparam int unsigned RS_DEPTH = 4;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ret_stack.sv
// LIFO return-address stack.
//   i_clk, i_rst_n : clock, async active-low clear
//   i_clr          : synchronous clear (empties the stack)
//   i_push, i_data : push i_data when not full
//   i_pop          : pop when not empty
//   o_full_c, o_empty_c, o_top_c : decoded status and top-of-stack entry
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned DEPTH = RS_DEPTH
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_push,
  input  logic i_pop,
  input  pc_t  i_data,
  output logic o_full_c,
  output logic o_empty_c,
  output pc_t  o_top_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  pc_t           r_mem [DEPTH];
  logic [CW-1:0] r_depth;

  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_top_idx;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_wr_idx  = r_depth[AW-1:0];
  assign w_top_idx = AW'(r_depth - CW'(1));
  assign o_full_c  = (r_depth == CW'(DEPTH));
  assign o_empty_c = (r_depth == '0);
  assign o_top_c   = r_mem[w_top_idx];
  assign w_do_push = i_push && !o_full_c && !i_clr;
  assign w_do_pop  = i_pop && !o_empty_c && !i_clr;

  // Depth counter; clear wins over push/pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_depth <= '0;
    end else if (i_clr) begin
      r_depth <= '0;
    end else if (w_do_push) begin
      r_depth <= r_depth + CW'(1);
    end else if (w_do_pop) begin
      r_depth <= r_depth - CW'(1);
    end
  end

  // Entry storage; contents above the depth pointer are don't-care.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter and branch sequencer for the fetch stage.
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_start          : start pulse (from IDLE or DONE), restarts at PC 0
//   i_stall          : freeze all state this cycle (RUN)
//   i_branch, i_cond : conditional LUT jump, taken when both high
//   i_call, i_ret    : call through LUT / return via stack
//   i_halt           : end of program, enter DONE
//   i_jptr, o_jptr_c : LUT pointer, combinational pass-through
//   i_jump           : LUT target for o_jptr_c (same cycle)
//   o_pc             : fetch address
//   o_busy, o_done   : RUN / DONE indicators
//   o_stack_err      : sticky stack over/underflow, cleared by start
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stall,
  input  logic              i_branch,
  input  logic              i_cond,
  input  logic              i_call,
  input  logic              i_ret,
  input  logic              i_halt,
  input  logic [JPTR_W-1:0] i_jptr,
  input  pc_t               i_jump,
  output logic [JPTR_W-1:0] o_jptr_c,
  output pc_t               o_pc,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_stack_err
);

  state_e r_state;
  pc_t    r_pc;
  logic   r_busy;
  logic   r_done;
  logic   r_err;

  pc_t    w_pc_inc;
  pc_t    w_top;
  logic   w_full;
  logic   w_empty;
  logic   w_advance;
  logic   w_clr;
  logic   w_push;
  logic   w_pop;

  assign o_jptr_c    = i_jptr;
  assign o_pc        = r_pc;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_stack_err = r_err;

  assign w_pc_inc = r_pc + PC_W'(1);

  // Stack control follows the same priority as the PC update below.
  always_comb begin
    w_advance = 1'b0;
    w_clr     = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_advance = (r_state == ST_RUN) && !i_stall && !i_halt;
    w_clr     = i_start && (r_state != ST_RUN);
    w_pop     = w_advance && i_ret && !w_empty;
    w_push    = w_advance && !i_ret && i_call && !w_full;
  end

  ret_stack #(.DEPTH(RS_DEPTH)) u_ret_stack (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_clr),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_data    (w_pc_inc),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_top_c   (w_top)
  );

  // Sequencer FSM with registered PC and status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state <= ST_RUN;
            r_pc    <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!i_stall) begin
            if (i_halt) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (i_ret) begin
              if (w_empty) begin
                r_err <= 1'b1;
                r_pc  <= w_pc_inc;
              end else begin
                r_pc  <= w_top;
              end
            end else if (i_call) begin
              // Overflowing call still jumps; only the push is dropped.
              if (w_full) r_err <= 1'b1;
              r_pc <= i_jump;
            end else if (i_branch && i_cond) begin
              r_pc <= i_jump;
            end else begin
              r_pc <= w_pc_inc;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_pc    <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
